riscv_data_mem_responder: RTL
=============================

# riscv_data_mem_responder

Memory-side responder for the core's data req/gnt/rvalid interface. It drives the grant, error and response signals that the load/store unit consumes. It backs a single word-organised SRAM array with byte-enabled writes, address range checking, and programmable grant wait states for stall testing. It sits between the core's data port and the testbench/system memory map, and has a side-band preload port for program/data initialisation.

## Interface
- ADDR_WIDTH, 12, word-address bits of the array (depth 2^ADDR_WIDTH words of 32 bits)
- BASE_ADDR, 32'h0001_0000, byte address of word 0; must be 4-byte aligned
- GNT_WAIT, 0, minimum cycles data_req_i must be held before data_gnt_o can assert (0..15)

Ports (reset is rst_n, asynchronous, active-low; clock is clk):
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- data_req_i  in  1  request from core
- data_gnt_o  out  1  request accepted this cycle (combinational)
- data_rvalid_o  out  1  response valid (registered)
- data_err_o  out  1  access error, valid only together with data_gnt_o
- data_addr_i  in  32  byte address
- data_we_i  in  1  1 = store, 0 = load
- data_be_i  in  4  byte enables, already aligned to the word lane
- data_wdata_i  in  32  store data, already rotated to lanes
- data_rdata_o  out  32  load data, valid with data_rvalid_o
- stall_i  in  1  extra grant suppression, for bench-injected wait states
- init_we_i  in  1  preload write strobe
- init_addr_i  in  ADDR_WIDTH  preload word index
- init_wdata_i  in  32  preload data, full-word write

## Operation
- Word index = (data_addr_i − BASE_ADDR) >> 2. Bits [1:0] are ignored because the core has already split misaligned accesses and shifted the BE.
- in_range = data_addr_i ≥ BASE_ADDR and data_addr_i < BASE_ADDR + 4·2^ADDR_WIDTH. The comparison is 33-bit, with no wrap at 32'hFFFF_FFFF.
- Wait counter wcnt (4 bits, saturating at GNT_WAIT):
  - Increments each cycle that data_req_i=1 and data_gnt_o=0.
  - Clears on grant or when data_req_i=0.
- data_gnt_o = data_req_i & (wcnt == GNT_WAIT) & ~stall_i & ~init_we_i.
- data_err_o = data_gnt_o & ~in_range. It is 0 whenever data_gnt_o=0.
- On a granted store with in_range:
  - Write mem[idx] bytes where data_be_i[k]=1 at the grant edge.
  - data_be_i=0 writes nothing but is still acknowledged.
- On a granted load with in_range: capture mem[idx] into the rdata register at the grant edge.
- Errored access:
  - No memory write.
  - rvalid still issued, with data_rdata_o = 32'h0.
- Store response: rvalid issued, data_rdata_o = 32'h0.
- Response register rvalid_q is set at every grant edge and cleared otherwise.
- FSM states:
  - IDLE: no pending response.
  - RESP: rvalid_q=1.
  - IDLE→RESP on grant.
  - RESP→RESP on a new grant in the same cycle (back-to-back).
  - RESP→IDLE otherwise.
- At most one outstanding transaction by construction.
- Preload: init_we_i writes init_wdata_i to mem[init_addr_i] at the edge. It has priority; core grants are blocked that cycle (wcnt keeps counting).

## Timing
- Reset values: data_rvalid_o=0, data_rdata_o=0, data_gnt_o=0 (req low), data_err_o=0, wcnt=0, FSM=IDLE. Memory contents are not reset.
- GNT_WAIT=0 with no stall: grant is in the same cycle as req.
- Grant latency is GNT_WAIT cycles after req first rises, plus one cycle per stall_i or init_we_i cycle once the count is reached.
- Response latency: rvalid exactly 1 cycle after the grant cycle, held for exactly 1 cycle. No rvalid without a preceding grant.
- Back-to-back: req held across rvalid with GNT_WAIT=0 gives gnt every cycle and rvalid every cycle, one cycle behind.
- Read-after-write: a load granted the cycle after a store to the same word returns the updated bytes.
- Preload to the same word as a core access: the access is not granted that cycle, so there is no conflict.
- req deasserted before grant: wcnt clears, no side effects.
- Reset asserted mid-response: rvalid drops immediately (asynchronous) and the pending response is discarded.

## Test plan
- Preload mem[0]=32'hDEAD_BEEF, then load at 32'h0001_0000 with GNT_WAIT=0 → gnt same cycle, rvalid next cycle, rdata=32'hDEAD_BEEF, err=0.
- Store 32'h1122_3344 with be=4'b0110 to a word preloaded as 32'hAAAA_AAAA, then load the same word → rdata=32'hAA22_33AA, store rvalid rdata=0.
- Load at 32'h0000_FFFC and at BASE+4·2^ADDR_WIDTH → err=1 with gnt, rvalid next cycle with rdata=0. A store to the same addresses leaves memory unchanged.
- GNT_WAIT=3 with stall_i high for 2 cycles after the count is reached → gnt exactly 5 cycles after req rises, rvalid 1 cycle later.
- Continuous req for 4 loads from consecutive words, GNT_WAIT=0 → 4 consecutive gnt cycles, 4 consecutive rvalid cycles with the matching data in order.
- Assert rst_n low the cycle after a grant → rvalid=0 immediately. After release, no stray rvalid, and a new request completes normally.

Source files
------------

// File: rtl/riscv_data_mem_responder.sv
// Data-side memory responder for the core's req/gnt/rvalid port: one word-organised
// SRAM with byte-enabled stores, range checking, programmable grant wait states and a preload port.
module riscv_data_mem_responder #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
    parameter int          GNT_WAIT   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  data_req_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic                  data_err_o,
    input  logic [31:0]           data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [31:0]           data_wdata_i,
    output logic [31:0]           data_rdata_o,
    input  logic                  stall_i,
    input  logic                  init_we_i,
    input  logic [ADDR_WIDTH-1:0] init_addr_i,
    input  logic [31:0]           init_wdata_i
);

    localparam int          DATA_W    = 32;
    localparam int          DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [32:0] BASE_EXT  = {1'b0, BASE_ADDR};
    localparam logic [32:0] LIMIT_EXT = BASE_EXT + (33'd4 << ADDR_WIDTH);
    localparam logic [3:0]  WAIT_MAX  = 4'(GNT_WAIT);

    typedef enum logic {IDLE, RESP} state_t;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [31:0]           offset;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  in_range;
    logic [3:0]            wcnt;
    state_t                state;
    logic [DATA_W-1:0]     rdata_p1;
    logic                  unused_offset_bits;

    assign offset   = data_addr_i - BASE_ADDR;
    assign idx      = offset[ADDR_WIDTH+1:2];
    // 33-bit compare so a window ending at the top of the address space cannot wrap.
    assign in_range = ({1'b0, data_addr_i} >= BASE_EXT) && ({1'b0, data_addr_i} < LIMIT_EXT);

    assign unused_offset_bits = ^{offset[31:ADDR_WIDTH+2], offset[1:0]};

    assign data_gnt_o    = data_req_i & (wcnt == WAIT_MAX) & ~stall_i & ~init_we_i;
    assign data_err_o    = data_gnt_o & ~in_range;
    assign data_rvalid_o = (state == RESP);
    assign data_rdata_o  = rdata_p1;

    // Wait counter: saturates at the programmed count, restarts on grant or dropped request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= 4'd0;
        end else if (!data_req_i || data_gnt_o) begin
            wcnt <= 4'd0;
        end else if (wcnt != WAIT_MAX) begin
            wcnt <= wcnt + 4'd1;
        end
    end

    // Response stage: one registered response per grant; stores and errors return zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rdata_p1 <= '0;
        end else begin
            case (state)
                IDLE:    state <= data_gnt_o ? RESP : IDLE;
                RESP:    state <= data_gnt_o ? RESP : IDLE;
                default: state <= IDLE;
            endcase
            if (data_gnt_o) begin
                rdata_p1 <= (!data_we_i && in_range) ? mem[idx] : '0;
            end
        end
    end

    // Preload owns the array in its cycle; grants are already blocked then, so no port conflict.
    always_ff @(posedge clk) begin
        if (init_we_i) begin
            mem[init_addr_i] <= init_wdata_i;
        end else if (data_gnt_o && data_we_i && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

endmodule
